picorv32_mem_responder: RTL and testbench

Single-port word RAM that answers the picorv32 native memory interface (`mem_valid`/`mem_ready` handshake) as its responder. It is the memory end of the core's memory bus and is driven directly by the core or by the dual-core comparison wrapper outputs. It models a programmable number of wait states, performs byte-strobed writes, and counts completed transactions for testbench checking.

---
 rtl/picorv32_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_picorv32_mem_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder: single-port word RAM answering the picorv32 native
// memory interface (mem_valid/mem_ready), with programmable wait states,
// byte-strobed writes and transaction counters.
//
// Optional feature macro: MEM_RESP_BUS_ERR_EN
//   defined   -> addresses above the RAM range flag bus_err, reads return
//                32'hDEADBEEF and writes are suppressed
//   undefined -> upper address bits are ignored (aliasing), bus_err is 0
//
// Ports:
//   clk        clock, rising edge
//   clear      synchronous active-high reset (FSM/outputs/counters, not RAM)
//   mem_valid  request valid, held until mem_ready
//   mem_instr  instruction-fetch qualifier (counted only)
//   mem_addr   byte address, bits [1:0] ignored
//   mem_wdata  write data
//   mem_wstrb  byte enables, 0 = read
//   mem_ready  one-cycle completion pulse
//   mem_rdata  read data, valid with mem_ready, held otherwise
//   bus_err    out-of-range flag, coincident with mem_ready
//   rd_count   completed reads
//   wr_count   completed writes
//   if_count   completed reads with mem_instr=1
module picorv32_mem_responder #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] if_count
);

    localparam int unsigned WORDS = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    logic [31:0]          mem_q [WORDS];
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q;
    logic                 oor_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 instr_q;
    logic                 ready_q, err_q;
    logic [31:0]          rdata_q;
    logic [31:0]          rd_cnt_q, wr_cnt_q, if_cnt_q;

    logic                 accept_c;
    logic                 resp_enter_c;
    logic [ADDR_BITS-1:0] idx_in_c, rsp_idx_c;
    logic                 oor_in_c, rsp_oor_c, rsp_wr_c;
    logic                 unused_addr_c;

    assign idx_in_c = mem_addr[ADDR_BITS+1:2];

`ifdef MEM_RESP_BUS_ERR_EN
    assign oor_in_c      = |mem_addr[31:ADDR_BITS+2];
    assign unused_addr_c = ^mem_addr[1:0];
`else
    assign oor_in_c      = 1'b0;
    assign unused_addr_c = ^{mem_addr[31:ADDR_BITS+2], mem_addr[1:0]};
`endif

    // With zero latency RESP is entered straight from IDLE, so the response
    // must be built from the live request rather than the latched copy.
    assign rsp_idx_c = (state_q == ST_IDLE) ? idx_in_c   : idx_q;
    assign rsp_oor_c = (state_q == ST_IDLE) ? oor_in_c   : oor_q;
    assign rsp_wr_c  = (state_q == ST_IDLE) ? |mem_wstrb : |wstrb_q;

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept_c     = 1'b0;
        resp_enter_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    accept_c = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        resp_enter_c = (state_d == ST_RESP) && (state_q != ST_RESP);
    end

    // State, request latch, outputs and counters
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            instr_q  <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            if_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_c) begin
                idx_q   <= idx_in_c;
                oor_q   <= oor_in_c;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
            end
            ready_q <= resp_enter_c;
            err_q   <= resp_enter_c & rsp_oor_c;
            if (resp_enter_c && !rsp_wr_c) begin
                rdata_q <= rsp_oor_c ? 32'hDEAD_BEEF : mem_q[rsp_idx_c];
            end
            if (state_q == ST_RESP) begin
                if (wstrb_q == '0) begin
                    rd_cnt_q <= rd_cnt_q + 32'd1;
                    if (instr_q) begin
                        if_cnt_q <= if_cnt_q + 32'd1;
                    end
                end else begin
                    wr_cnt_q <= wr_cnt_q + 32'd1;
                end
            end
        end
    end

    // RAM write commits on the edge closing RESP; clear discards it
    always_ff @(posedge clk) begin
        if (!clear && (state_q == ST_RESP) && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign bus_err   = err_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign if_count  = if_cnt_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Testbench for picorv32_mem_responder: four instances at LATENCY 0/1/4/15,
// directed cases plus randomized traffic against a behavioural model.
module tb_picorv32_mem_responder;

    localparam int NDUT = 4;

`ifdef MEM_RESP_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear_r [NDUT];
    logic        valid_r [NDUT];
    logic        instr_r [NDUT];
    logic [31:0] addr_r  [NDUT];
    logic [31:0] wdata_r [NDUT];
    logic [3:0]  wstrb_r [NDUT];

    logic        ready_w [NDUT];
    logic [31:0] rdata_w [NDUT];
    logic        err_w   [NDUT];
    logic [31:0] rdc_w   [NDUT];
    logic [31:0] wrc_w   [NDUT];
    logic [31:0] ifc_w   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned LAT_G = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 4 : 15;
        picorv32_mem_responder #(.ADDR_BITS(12), .LATENCY(LAT_G)) u_dut (
            .clk       (clk),
            .clear     (clear_r[g]),
            .mem_valid (valid_r[g]),
            .mem_instr (instr_r[g]),
            .mem_addr  (addr_r[g]),
            .mem_wdata (wdata_r[g]),
            .mem_wstrb (wstrb_r[g]),
            .mem_ready (ready_w[g]),
            .mem_rdata (rdata_w[g]),
            .bus_err   (err_w[g]),
            .rd_count  (rdc_w[g]),
            .wr_count  (wrc_w[g]),
            .if_count  (ifc_w[g])
        );
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    // Behavioural model state
    logic [31:0] m_mem   [NDUT][4096];
    logic [31:0] m_rdata [NDUT];
    int unsigned m_rd [NDUT];
    int unsigned m_wr [NDUT];
    int unsigned m_if [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_rd[k] = 0;
        m_wr[k] = 0;
        m_if[k] = 0;
        m_rdata[k] = 32'h0;
    endtask

    // One completed transaction in the model; returns expected bus_err
    task automatic model_xact(input int k, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input logic ins, output logic exp_err);
        bit oor;
        int idx;
        oor = ERR_EN && ((a / 32'd16384) != 0);
        idx = int'((a / 32'd4) % 32'd4096);
        exp_err = oor;
        if (ws == 4'h0) begin
            m_rd[k]++;
            if (ins) m_if[k]++;
            m_rdata[k] = oor ? 32'hDEADBEEF : m_mem[k][idx];
        end else begin
            m_wr[k]++;
            if (!oor) begin
                for (int i = 0; i < 4; i++)
                    if (ws[i]) m_mem[k][idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    task automatic check_cnt(input int k);
        check_eq($sformatf("rd_count[%0d]", k), rdc_w[k], m_rd[k]);
        check_eq($sformatf("wr_count[%0d]", k), wrc_w[k], m_wr[k]);
        check_eq($sformatf("if_count[%0d]", k), ifc_w[k], m_if[k]);
    endtask

    // Single request: checks latency, rdata, bus_err, pulse width and counters
    task automatic do_xact(input int k, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic ins,
                           output logic [31:0] rd_seen, output logic err_seen);
        int  n;
        bit  got;
        logic exp_err;
        @(negedge clk);
        valid_r[k] = 1'b1;
        addr_r[k]  = a;
        wdata_r[k] = wd;
        wstrb_r[k] = ws;
        instr_r[k] = ins;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_w[k]) got = 1'b1;
        end
        check_eq($sformatf("latency[%0d]", k), n, lat_of(k) + 1);
        model_xact(k, a, wd, ws, ins, exp_err);
        rd_seen  = rdata_w[k];
        err_seen = err_w[k];
        check_eq($sformatf("rdata[%0d]", k), rd_seen, m_rdata[k]);
        check_eq($sformatf("bus_err[%0d]", k), {31'h0, err_seen}, {31'h0, exp_err});
        @(negedge clk);
        valid_r[k] = 1'b0;
        @(posedge clk);
        #1;
        check_eq($sformatf("ready_pulse[%0d]", k), {31'h0, ready_w[k]}, 32'h0);
        check_cnt(k);
    endtask

    // Reads with mem_valid held high across several completions
    task automatic b2b_reads(input int k, input logic [31:0] a);
        int   cyc, last, pulses;
        logic exp_err;
        @(negedge clk);
        valid_r[k] = 1'b1;
        addr_r[k]  = a;
        wstrb_r[k] = 4'h0;
        instr_r[k] = 1'b1;
        cyc = 0;
        last = 0;
        pulses = 0;
        while (pulses < 4 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ready_w[k]) begin
                if (pulses == 0)
                    check_eq($sformatf("b2b_first[%0d]", k), cyc, lat_of(k) + 1);
                else
                    check_eq($sformatf("b2b_period[%0d]", k), cyc - last, lat_of(k) + 2);
                model_xact(k, a, 32'h0, 4'h0, 1'b1, exp_err);
                check_eq($sformatf("b2b_rdata[%0d]", k), rdata_w[k], m_rdata[k]);
                last = cyc;
                pulses++;
            end
        end
        check_eq($sformatf("b2b_pulses[%0d]", k), pulses, 4);
        @(negedge clk);
        valid_r[k] = 1'b0;
        @(posedge clk);
        #1;
        check_cnt(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          seen;

        for (int k = 0; k < NDUT; k++) begin
            clear_r[k] = 1'b1;
            valid_r[k] = 1'b0;
            instr_r[k] = 1'b0;
            addr_r[k]  = 32'h0;
            wdata_r[k] = 32'h0;
            wstrb_r[k] = 4'h0;
            model_reset(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) clear_r[k] = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("rst_ready[%0d]", k), {31'h0, ready_w[k]}, 32'h0);
            check_eq($sformatf("rst_rdata[%0d]", k), rdata_w[k], 32'h0);
            check_eq($sformatf("rst_err[%0d]", k), {31'h0, err_w[k]}, 32'h0);
            check_cnt(k);
        end

        // Back-to-back fetches at LATENCY 0 and 15
        do_xact(0, 32'h20, 32'h0BAD_F00D, 4'hF, 1'b0, rd, er);
        b2b_reads(0, 32'h20);
        do_xact(3, 32'h20, 32'h1357_9BDF, 4'hF, 1'b0, rd, er);
        b2b_reads(3, 32'h20);

        // Write/read and partial write at LATENCY 1
        do_xact(1, 32'h10, 32'h1234_5678, 4'hF, 1'b0, rd, er);
        check_eq("dir_wr_count", wrc_w[1], 32'd1);
        do_xact(1, 32'h10, 32'h0, 4'h0, 1'b0, rd, er);
        check_eq("dir_read", rd, 32'h1234_5678);
        check_eq("dir_rd_count", rdc_w[1], 32'd1);
        do_xact(1, 32'h10, 32'hAABB_CCDD, 4'h5, 1'b0, rd, er);
        do_xact(1, 32'h10, 32'h0, 4'h0, 1'b0, rd, er);
        check_eq("partial_write", rd, 32'h12BB_56DD);

        // Out-of-range / aliasing read
        do_xact(1, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b0, rd, er);
        do_xact(1, 32'h0001_0000, 32'h0, 4'h0, 1'b0, rd, er);
        check_eq("oor_rdata", rd, ERR_EN ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
        check_eq("oor_err", {31'h0, er}, {31'h0, ERR_EN});

        // clear during WAIT of a write at LATENCY 4
        do_xact(2, 32'h40, 32'h0, 4'hF, 1'b0, rd, er);
        @(negedge clk);
        valid_r[2] = 1'b1;
        addr_r[2]  = 32'h40;
        wdata_r[2] = 32'hFFFF_FFFF;
        wstrb_r[2] = 4'hF;
        @(negedge clk);
        clear_r[2] = 1'b1;
        valid_r[2] = 1'b0;
        @(negedge clk);
        clear_r[2] = 1'b0;
        model_reset(2);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ready_w[2]) seen++;
        end
        check_eq("clr_no_ready", seen, 0);
        check_cnt(2);
        do_xact(2, 32'h40, 32'h0, 4'h0, 1'b0, rd, er);
        check_eq("clr_readback", rd, 32'h0);

        // Randomized traffic on every instance
        for (int k = 0; k < NDUT; k++) begin
            for (int w = 0; w < 16; w++)
                do_xact(k, 32'(w) * 32'd4, $urandom, 4'hF, 1'b0, rd, er);
            for (int t = 0; t < 25; t++) begin
                logic [31:0] a, up;
                logic [3:0]  ws;
                up = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 255)) : 32'h0;
                a  = up * 32'd16384 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
                ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                do_xact(k, a, $urandom, ws, 1'($urandom_range(0, 1)), rd, er);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
